// File: rtl/text_ram.sv
// Multi-line ASCII character store with a registered read port, a runtime
// character write port and a number-to-ASCII field loader.
module text_ram #(
  parameter TEXT = "START GAME",
  parameter int unsigned LINES = 2,
  parameter int unsigned COLS = 16,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned VAL_W = 10,
  parameter bit LEAD_ZERO = 1'b1,
  localparam int unsigned LW = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LW-1:0]    char_line,
  input  logic [CW-1:0]    char_col,
  output logic [6:0]       char_code,
  input  logic             wr_en,
  input  logic [LW-1:0]    wr_line,
  input  logic [CW-1:0]    wr_col,
  input  logic [6:0]       wr_char,
  input  logic             num_start,
  input  logic [VAL_W-1:0] num_value,
  input  logic [LW-1:0]    num_line,
  input  logic [CW-1:0]    num_col,
  output logic             num_busy,
  output logic             num_done
);

  localparam int unsigned NUM      = LINES * COLS;
  localparam int unsigned IW       = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned BW       = 4 * DIGITS;
  localparam int unsigned TEXT_LEN = $bits(TEXT) / 8;
  localparam int unsigned CNT_N    = (VAL_W > DIGITS) ? VAL_W : DIGITS;
  localparam int unsigned CNTW     = $clog2(CNT_N + 1);

  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  typedef logic [6:0] mem_t [NUM];
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE, S_DONE} state_e;

  // First character of the string sits at the top byte of the literal.
  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (i < TEXT_LEN) m[i] = TEXT[8*(TEXT_LEN-1-i) +: 7];
      else              m[i] = 7'h20;
    end
    return m;
  endfunction

  mem_t mem_q = init_mem();

  state_e           state_q, state_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [LW-1:0]    line_q, line_d;
  logic [CW-1:0]    col_q, col_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             nz_q, nz_d;
  logic [6:0]       char_code_q, char_code_d;
  logic             num_busy_q, num_busy_d;
  logic             num_done_q, num_done_d;

  logic             mem_we;
  logic [IW-1:0]    mem_waddr;
  logic [6:0]       mem_wdata;
  logic [BW-1:0]    adj;
  logic [3:0]       digit;
  logic             last_digit;
  logic             blank;
  int unsigned      wcol;

  // Read port: out-of-range addresses read as a space.
  always_comb begin
    char_code_d = 7'h20;
    if ((32'(char_line) < LINES) && (32'(char_col) < COLS))
      char_code_d = mem_q[IW'(32'(char_line) * COLS + 32'(char_col))];
  end

  // Loader next-state, BCD conversion and memory write selection.
  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    bcd_d      = bcd_q;
    line_d     = line_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    nz_d       = nz_q;
    num_busy_d = (state_q == S_CONV) || (state_q == S_WRITE);
    num_done_d = (state_q == S_DONE);
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    adj        = bcd_q;
    digit      = bcd_q[BW-1 -: 4];
    last_digit = (cnt_q == CNTW'(DIGITS - 1));
    blank      = 1'b0;
    wcol       = 32'(col_q) + 32'(cnt_q);

    if (wr_en && !num_busy_q && (32'(wr_line) < LINES) && (32'(wr_col) < COLS)) begin
      mem_we    = 1'b1;
      mem_waddr = IW'(32'(wr_line) * COLS + 32'(wr_col));
      mem_wdata = wr_char;
    end

    case (state_q)
      S_IDLE: begin
        if (num_start) begin
          val_d   = (64'(num_value) > MAX_VAL) ? VAL_W'(MAX_VAL) : num_value;
          line_d  = num_line;
          col_d   = num_col;
          bcd_d   = '0;
          cnt_d   = '0;
          nz_d    = 1'b0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        for (int unsigned i = 0; i < DIGITS; i++)
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        bcd_d = (adj << 1) | BW'(val_q[VAL_W-1]);
        val_d = val_q << 1;
        if (cnt_q == CNTW'(VAL_W - 1)) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_WRITE: begin
        blank = !LEAD_ZERO && !nz_q && (digit == 4'd0) && !last_digit;
        if (digit != 4'd0) nz_d = 1'b1;
        // Columns past the line end are skipped rather than wrapped.
        if ((32'(line_q) < LINES) && (wcol < COLS)) begin
          mem_we    = 1'b1;
          mem_waddr = IW'(32'(line_q) * COLS + wcol);
          mem_wdata = blank ? 7'h20 : (7'h30 + 7'(digit));
        end
        bcd_d = bcd_q << 4;
        if (last_digit) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      val_q       <= '0;
      bcd_q       <= '0;
      line_q      <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      nz_q        <= 1'b0;
      char_code_q <= 7'h00;
      num_busy_q  <= 1'b0;
      num_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      bcd_q       <= bcd_d;
      line_q      <= line_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      nz_q        <= nz_d;
      char_code_q <= char_code_d;
      num_busy_q  <= num_busy_d;
      num_done_q  <= num_done_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign char_code = char_code_q;
  assign num_busy  = num_busy_q;
  assign num_done  = num_done_q;

endmodule

// File: tb/tb_text_ram.sv
// Scoreboard bench for text_ram: two instances (leading zeros on / off)
// share stimulus and are compared against a character-array reference model.
module tb_text_ram;

  localparam int LINES  = 2;
  localparam int COLS   = 16;
  localparam int DIGITS = 3;
  localparam int VAL_W  = 10;
  localparam int NUM    = LINES * COLS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       char_line = 1'b0;
  logic [3:0] char_col = '0;
  logic       wr_en = 1'b0;
  logic       wr_line = 1'b0;
  logic [3:0] wr_col = '0;
  logic [6:0] wr_char = '0;
  logic       num_start = 1'b0;
  logic [9:0] num_value = '0;
  logic       num_line = 1'b0;
  logic [3:0] num_col = '0;
  logic [6:0] code_a, code_b;
  logic       busy_a, busy_b, done_a, done_b;

  int cyc = 0;
  int win_s = -1000;
  int n_chk = 0;
  int n_pass = 0;
  logic rd_vld = 1'b0;
  logic rd_pipe = 1'b0;
  logic [6:0] mdl [2][NUM];
  int rdq[$];
  int doneq[$];

  text_ram #(.LEAD_ZERO(1'b1)) u_lz1 (
    .clk(clk), .rst_n(rst_n), .char_line(char_line), .char_col(char_col),
    .char_code(code_a), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
    .wr_char(wr_char), .num_start(num_start), .num_value(num_value),
    .num_line(num_line), .num_col(num_col), .num_busy(busy_a), .num_done(done_a)
  );

  text_ram #(.LEAD_ZERO(1'b0)) u_lz0 (
    .clk(clk), .rst_n(rst_n), .char_line(char_line), .char_col(char_col),
    .char_code(code_b), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
    .wr_char(wr_char), .num_start(num_start), .num_value(num_value),
    .num_line(num_line), .num_col(num_col), .num_busy(busy_b), .num_done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rd_pipe <= rd_vld;
  end

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops read expectations, checks busy window and done timing.
  always @(negedge clk) begin : mon
    int e;
    int exp_busy;
    if (rd_pipe && rdq.size() > 0) begin
      e = rdq.pop_front();
      check($sformatf("read_lz1 idx %0d", e >>> 14), int'(code_a), e & 32'h7f);
      check($sformatf("read_lz0 idx %0d", e >>> 14), int'(code_b), (e >>> 7) & 32'h7f);
    end
    if (rst_n === 1'b1) begin
      exp_busy = ((cyc >= win_s + 1) && (cyc <= win_s + VAL_W + DIGITS)) ? 1 : 0;
      check("busy_lz1", int'(busy_a), exp_busy);
      check("busy_lz0", int'(busy_b), exp_busy);
      if (done_a || done_b) begin
        if (doneq.size() == 0) begin
          check("done_unexpected", int'({done_b, done_a}), 0);
        end else begin
          check("done_edge", cyc, doneq.pop_front());
          check("done_both", int'({done_b, done_a}), 3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] field_ch(int v, int k, bit lz);
    int sv, p;
    sv = (v > 999) ? 999 : v;
    p = 1;
    for (int j = 0; j < DIGITS - 1 - k; j++) p = p * 10;
    if (!lz && (k < DIGITS - 1) && (sv < p)) return 7'h20;
    return 7'(32'h30 + (sv / p) % 10);
  endfunction

  task automatic model_field(int v, int l, int c, int nd);
    for (int k = 0; k < nd; k++)
      if (c + k < COLS) begin
        mdl[0][l*COLS + c + k] = field_ch(v, k, 1'b1);
        mdl[1][l*COLS + c + k] = field_ch(v, k, 1'b0);
      end
  endtask

  // One cycle: optional read (expected taken before any same-cycle write) and write.
  task automatic op(bit rd, int rl, int rc, bit we, int wl, int wc, logic [6:0] ch);
    int idx;
    idx = rl * COLS + rc;
    char_line = 1'(rl);
    char_col  = 4'(rc);
    rd_vld    = rd;
    if (rd) rdq.push_back((idx << 14) | (int'(mdl[1][idx]) << 7) | int'(mdl[0][idx]));
    wr_en   = we;
    wr_line = 1'(wl);
    wr_col  = 4'(wc);
    wr_char = ch;
    if (we) begin
      mdl[0][wl*COLS + wc] = ch;
      mdl[1][wl*COLS + wc] = ch;
    end
    tick();
    rd_vld = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic readback();
    for (int i = 0; i < NUM; i++) op(1'b1, i / COLS, i % COLS, 1'b0, 0, 0, 7'h0);
  endtask

  task automatic load(int v, int l, int c, bit noisy, bit cut);
    int s;
    num_start = 1'b1;
    num_value = 10'(v);
    num_line  = 1'(l);
    num_col   = 4'(c);
    s = cyc + 1;
    win_s = s;
    doneq.push_back(s + VAL_W + DIGITS + 1);
    tick();
    num_start = 1'b0;
    while (cyc < s + VAL_W + (cut ? 1 : DIGITS + 1)) begin
      if (noisy && cyc >= s + 1 && cyc <= s + VAL_W + DIGITS) begin
        wr_en     = ($urandom_range(0, 1) == 0);
        wr_line   = 1'($urandom_range(0, 1));
        wr_col    = 4'($urandom_range(0, 15));
        wr_char   = 7'($urandom_range(33, 126));
        num_start = ($urandom_range(0, 2) == 0);
        num_value = 10'($urandom_range(0, 1023));
      end
      tick();
      wr_en     = 1'b0;
      num_start = 1'b0;
    end
    if (!cut) begin
      model_field(v, l, c, DIGITS);
    end else begin
      // Reset lands right after the first digit has been stored.
      model_field(v, l, c, 1);
      win_s = -1000;
      doneq.delete();
      rst_n = 1'b0;
      #1;
      check("rst_busy_lz1", int'(busy_a), 0);
      check("rst_busy_lz0", int'(busy_b), 0);
      check("rst_done_lz1", int'(done_a), 0);
      check("rst_done_lz0", int'(done_b), 0);
      check("rst_code_lz1", int'(code_a), 0);
      check("rst_code_lz0", int'(code_b), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    string txt;
    int v;
    txt = "START GAME";
    for (int i = 0; i < NUM; i++) begin
      mdl[0][i] = (i < txt.len()) ? 7'(txt[i]) : 7'h20;
      mdl[1][i] = mdl[0][i];
    end

    rst_n = 1'b0;
    #1;
    check("reset_code_lz1", int'(code_a), 0);
    check("reset_code_lz0", int'(code_b), 0);
    check("reset_busy", int'({busy_b, busy_a}), 0);
    check("reset_done", int'({done_b, done_a}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    op(1'b1, 0, 0, 1'b0, 0, 0, 7'h0);
    op(1'b1, 0, 9, 1'b0, 0, 0, 7'h0);
    op(1'b1, 0, 10, 1'b0, 0, 0, 7'h0);
    op(1'b1, 1, 5, 1'b0, 0, 0, 7'h0);
    op(1'b1, 1, 3, 1'b1, 1, 3, 7'h58);
    op(1'b1, 1, 3, 1'b0, 0, 0, 7'h0);

    for (int i = 0; i < 200; i++)
      op($urandom_range(0, 1) == 1, $urandom_range(0, 1), $urandom_range(0, 15),
         $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 15),
         7'($urandom_range(32, 126)));
    readback();

    load(42, 1, 0, 1'b1, 1'b0);   readback();
    load(0, 0, 0, 1'b0, 1'b0);    readback();
    load(1023, 1, 4, 1'b1, 1'b0); readback();
    load(7, 1, 14, 1'b0, 1'b0);   readback();
    load(5, 0, 13, 1'b1, 1'b0);
    load(980, 0, 8, 1'b0, 1'b0);  readback();
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 1023);
      load(v, $urandom_range(0, 1), $urandom_range(0, 15), 1'b1, 1'b0);
      readback();
    end

    load(587, 1, 6, 1'b0, 1'b1);  readback();
    load(63, 1, 9, 1'b0, 1'b0);   readback();

    repeat (3) tick();
    check("done_pending", doneq.size(), 0);
    check("read_pending", rdq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/text_ram.md
# text_ram

Parametrised multi-line character store that supersedes the single-string character ROM in the Game_Control text path. It holds LINES × COLS 7-bit ASCII codes, preloaded from a string parameter, and serves a registered read port to the font/text renderer. It adds a runtime character write port and a number-to-ASCII loader FSM for live fields such as score, round and ammo.

## Interface
Parameters:
- TEXT, "START GAME", initial contents, line-major; positions beyond its length initialise to 0x20 (space)
- LINES, 2, number of text lines (≥1)
- COLS, 16, characters per line (≥1)
- DIGITS, 3, decimal digits written by the number loader (1..6)
- VAL_W, 10, width of num_value (≥1)
- LEAD_ZERO, 1, 1 = print leading zeros; 0 = replace leading zeros with space
- LW = $clog2(LINES) (min 1), CW = $clog2(COLS) (min 1), derived, not overridden

Ports (clock and reset first):
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- char_line  in  LW  read line index
- char_col  in  CW  read column index
- char_code  out  7  registered ASCII code at {char_line, char_col}
- wr_en  in  1  single-character write strobe
- wr_line  in  LW  write line index
- wr_col  in  CW  write column index
- wr_char  in  7  ASCII code to write
- num_start  in  1  1-cycle pulse: convert and write num_value
- num_value  in  VAL_W  unsigned value to print
- num_line  in  LW  field line
- num_col  in  CW  column of most significant digit
- num_busy  out  1  loader active
- num_done  out  1  1-cycle completion pulse

## Operation
- Storage: LINES*COLS entries, index = line*COLS + col, 7 bits each. Contents are not affected by rst_n.
- Read: char_code <= mem[idx] every cycle. If line ≥ LINES or col ≥ COLS, char_code <= 0x20.
- External write: when wr_en=1, num_busy=0 and the address is in range, mem[idx] <= wr_char. Out-of-range writes are dropped. wr_en is ignored while num_busy=1.
- Loader FSM states: IDLE, CONV, WRITE, DONE.
  - IDLE: on num_start=1, capture num_value, num_line and num_col, then go to CONV. If num_value > 10^DIGITS−1, the captured value saturates to 10^DIGITS−1 (all '9').
  - CONV: double-dabble, VAL_W cycles, on a 4*DIGITS-bit BCD register. Each cycle, add 3 to every nibble ≥5, then shift left one bit with the next value bit (MSB first). After VAL_W cycles, go to WRITE.
  - WRITE: DIGITS cycles. Cycle k (0 = most significant) writes ASCII (0x30 + BCD digit k) to column num_col+k.
    - If LEAD_ZERO=0, zero digits before the first nonzero digit are written as 0x20. The least significant digit is always a numeral.
    - Columns ≥ COLS are skipped; there is no wrap to the next line.
  - DONE: num_done=1 for one cycle, then go to IDLE.
- num_start outside IDLE is ignored.
- rst_n low: FSM goes to IDLE immediately, num_busy=0, num_done=0, char_code=0x00. A field interrupted mid-WRITE keeps the digits already written.

## Timing
- Read latency is 1 cycle: an address presented before edge N gives char_code valid after edge N.
- A read and a write to the same index in the same cycle return the old value (read-before-write). The new value is visible on the next read.
- External write takes effect at the edge where wr_en is sampled.
- Loader, with num_start sampled at edge 0:
  - num_busy=1 after edges 1 .. VAL_W+DIGITS.
  - Digit k is written at edge VAL_W+1+k.
  - num_done=1 and num_busy=0 after edge VAL_W+DIGITS+1.
  - The next num_start is accepted at the edge after num_done.
- Reset values: char_code=0x00, num_busy=0, num_done=0, FSM=IDLE.

## Test plan
- Power-up, default params → reading (0,0) gives 0x53 'S'; (0,9) gives 0x45 'E'; (0,10) and (1,5) give 0x20. Each result appears 1 cycle after the address.
- wr_en at (1,3) with 'X' (0x58), then read (1,3) → 0x58. A same-cycle read of (1,3) during the write returns 0x20.
- num_start, value 42, at (1,0), LEAD_ZERO=1 → (1,0..2) = "042" and num_done after edge 14. Repeat with LEAD_ZERO=0 → " 42". Value 0 with LEAD_ZERO=0 → "  0".
- Value 1023, DIGITS=3 → "999" (saturation). Field at col 14 with COLS=16 → cols 14,15 written; no write to line 2 or wrap to col 0.
- wr_en pulsed and num_start re-pulsed while num_busy=1 → both ignored; memory holds only the loader digits; exactly one num_done.
- rst_n asserted after the first digit is written → num_busy=0 and num_done=0 immediately. First digit retained, remaining columns unchanged; a new num_start after release completes normally.
